// File: rtl/mem_io_responder.sv
// Byte-wide CPU bus target: RAM plus I/O window with buffered UART TX/RX FIFOs.
// Latency: one cycle for RAM and I/O reads (registered mem_din); writes take effect at the edge.
// Backpressure: io_buffer_full warns the CPU ahead of TX overflow; rx_ready drops when RX is full.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH_WIDTH = 3,
  parameter int RX_DEPTH_WIDTH = 3,
  parameter int FULL_MARGIN    = 2,
  parameter     INIT_FILE      = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        sim_end,
  output logic        overflow_err
);

  localparam int TX_DEPTH = 1 << TX_DEPTH_WIDTH;
  localparam int RX_DEPTH = 1 << RX_DEPTH_WIDTH;
  localparam logic [TX_DEPTH_WIDTH:0] TX_FULL_CNT = TX_DEPTH[TX_DEPTH_WIDTH:0];
  localparam logic [RX_DEPTH_WIDTH:0] RX_FULL_CNT = RX_DEPTH[RX_DEPTH_WIDTH:0];
  localparam logic [TX_DEPTH_WIDTH:0] TX_MARGIN   = FULL_MARGIN[TX_DEPTH_WIDTH:0];

  // Address decode; the upper address bits are not part of the map.
  logic                      is_io, is_port0, is_port1;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic                      unused_addr_bits;
  assign is_io            = (mem_a[17:16] == 2'b11);
  assign is_port0         = (mem_a[17:0] == 18'h30000);
  assign is_port1         = (mem_a[17:0] == 18'h30004);
  assign ram_idx          = mem_a[RAM_ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^mem_a[31:18];

  // Byte RAM; contents survive reset, writes are blocked while reset is held.
  logic [7:0] ram [0:(1<<RAM_ADDR_WIDTH)-1];
  logic [7:0] ram_rd_q;
  logic       ram_we;
  assign ram_we = rst && mem_wr && !is_io;

  // Synchronous RAM port: read returns the pre-write byte on a same-address write.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= mem_dout;
    ram_rd_q <= ram[ram_idx];
  end

  // TX FIFO state
  logic [7:0]                tx_mem [0:TX_DEPTH-1];
  logic [TX_DEPTH_WIDTH-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TX_DEPTH_WIDTH:0]   tx_cnt_q, tx_cnt_d;
  logic                      tx_push, tx_pop, tx_drop;
  logic                      io_buffer_full_q, io_buffer_full_d;

  // RX FIFO state
  logic [7:0]                rx_mem [0:RX_DEPTH-1];
  logic [RX_DEPTH_WIDTH-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RX_DEPTH_WIDTH:0]   rx_cnt_q, rx_cnt_d;
  logic                      rx_push, rx_pop, rx_nonempty;

  // Read path and sticky flags
  logic       src_ram_q, src_ram_d;
  logic [7:0] io_rd_q, io_rd_d;
  logic       sim_end_q, sim_end_d;
  logic       overflow_err_q, overflow_err_d;

  assign tx_valid    = (tx_cnt_q != '0);
  assign tx_data     = tx_valid ? tx_mem[tx_rp_q] : 8'h00;
  assign rx_nonempty = (rx_cnt_q != '0);
  assign rx_ready    = rst && (rx_cnt_q != RX_FULL_CNT);

  // TX FIFO next state: writes to port 0 push when room remains, otherwise drop and flag.
  always_comb begin
    tx_push = 1'b0;
    tx_drop = 1'b0;
    if (rst && mem_wr && is_port0) begin
      if (tx_cnt_q < TX_FULL_CNT) tx_push = 1'b1;
      else                        tx_drop = 1'b1;
    end
    tx_pop           = tx_valid && tx_ready;
    tx_wp_d          = tx_wp_q + TX_DEPTH_WIDTH'(tx_push);
    tx_rp_d          = tx_rp_q + TX_DEPTH_WIDTH'(tx_pop);
    tx_cnt_d         = tx_cnt_q + (TX_DEPTH_WIDTH+1)'(tx_push) - (TX_DEPTH_WIDTH+1)'(tx_pop);
    io_buffer_full_d = ((TX_FULL_CNT - tx_cnt_d) <= TX_MARGIN);
  end

  // RX FIFO next state: UART pushes, CPU reads of port 0 pop when non-empty.
  always_comb begin
    rx_push  = rx_valid && rx_ready;
    rx_pop   = rst && !mem_wr && is_port0 && rx_nonempty;
    rx_wp_d  = rx_wp_q + RX_DEPTH_WIDTH'(rx_push);
    rx_rp_d  = rx_rp_q + RX_DEPTH_WIDTH'(rx_pop);
    rx_cnt_d = rx_cnt_q + (RX_DEPTH_WIDTH+1)'(rx_push) - (RX_DEPTH_WIDTH+1)'(rx_pop);
  end

  // Read-data selection for the next cycle, plus sticky flag updates.
  always_comb begin
    src_ram_d      = rst && !mem_wr && !is_io;
    io_rd_d        = 8'h00;
    if (rst && !mem_wr) begin
      if (is_port0 && rx_nonempty) io_rd_d = rx_mem[rx_rp_q];
      else if (is_port1)           io_rd_d = {6'b0, overflow_err_q, rx_nonempty};
    end
    sim_end_d      = sim_end_q || (rst && mem_wr && is_port1);
    overflow_err_d = overflow_err_q || tx_drop;
  end

  // FIFO data storage; no reset needed since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= mem_dout;
    if (rx_push) rx_mem[rx_wp_q] <= rx_data;
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wp_q          <= '0;
      tx_rp_q          <= '0;
      tx_cnt_q         <= '0;
      rx_wp_q          <= '0;
      rx_rp_q          <= '0;
      rx_cnt_q         <= '0;
      io_buffer_full_q <= 1'b0;
      src_ram_q        <= 1'b0;
      io_rd_q          <= 8'h00;
      sim_end_q        <= 1'b0;
      overflow_err_q   <= 1'b0;
    end else begin
      tx_wp_q          <= tx_wp_d;
      tx_rp_q          <= tx_rp_d;
      tx_cnt_q         <= tx_cnt_d;
      rx_wp_q          <= rx_wp_d;
      rx_rp_q          <= rx_rp_d;
      rx_cnt_q         <= rx_cnt_d;
      io_buffer_full_q <= io_buffer_full_d;
      src_ram_q        <= src_ram_d;
      io_rd_q          <= io_rd_d;
      sim_end_q        <= sim_end_d;
      overflow_err_q   <= overflow_err_d;
    end
  end

  assign mem_din        = src_ram_q ? ram_rd_q : io_rd_q;
  assign io_buffer_full = io_buffer_full_q;
  assign sim_end        = sim_end_q;
  assign overflow_err   = overflow_err_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios followed by random bus traffic,
// all outputs compared each cycle against a queue-based behavioural model.
module tb_mem_io_responder;

  localparam logic [31:0] P0 = 32'h0003_0000;
  localparam logic [31:0] P1 = 32'h0003_0004;
  localparam logic [31:0] RA = 32'h0000_0123;
  localparam int TXD = 8;
  localparam int RXD = 8;
  localparam int MARGIN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        sim_end;
  logic        overflow_err;

  mem_io_responder dut (
    .clk(clk), .rst(rst), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .sim_end(sim_end), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] ram_m[int];
  logic [7:0] sent_q[$];
  bit         m_ovf, m_end, m_full, m_din_known;
  logic [7:0] m_din;

  // Apply one bus transaction to the model, using the inputs held this cycle.
  task automatic model_edge();
    logic [17:0] a18;
    int idx, tx_n, rx_n;
    bit io;
    a18 = mem_a[17:0];
    idx = int'(mem_a[16:0]);
    io  = (a18 >= 18'h30000);
    if (!rst) begin
      tx_q.delete();
      rx_q.delete();
      m_ovf = 0; m_end = 0; m_full = 0;
      m_din = 8'h00; m_din_known = 1;
    end else begin
      tx_n = tx_q.size();
      rx_n = rx_q.size();
      m_din = 8'h00;
      m_din_known = 1;
      if (mem_wr) m_din_known = 0;
      else if (!io) begin
        if (ram_m.exists(idx)) m_din = ram_m[idx];
        else m_din_known = 0;
      end else if (a18 == 18'h30000) m_din = (rx_n != 0) ? rx_q[0] : 8'h00;
      else if (a18 == 18'h30004) m_din = {6'b0, m_ovf, rx_n != 0};
      if (tx_n > 0 && tx_ready) void'(tx_q.pop_front());
      if (mem_wr && a18 == 18'h30000) begin
        if (tx_n < TXD) tx_q.push_back(mem_dout);
        else m_ovf = 1;
      end
      if (!mem_wr && a18 == 18'h30000 && rx_n > 0) void'(rx_q.pop_front());
      if (rx_valid && rx_n < RXD) rx_q.push_back(rx_data);
      if (mem_wr && a18 == 18'h30004) m_end = 1;
      if (mem_wr && !io) ram_m[idx] = mem_dout;
      m_full = (TXD - tx_q.size()) <= MARGIN;
    end
  endtask

  // One clock cycle: drive, record emitted TX bytes, advance, compare.
  task automatic step(input logic r, input logic [31:0] a, input logic w, input logic [7:0] d,
                      input logic txr, input logic rxv, input logic [7:0] rxd);
    rst = r; mem_a = a; mem_wr = w; mem_dout = d;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    if (tx_valid === 1'b1 && txr) sent_q.push_back(tx_data);
    @(posedge clk);
    model_edge();
    #1;
    if (m_din_known) check("mem_din", mem_din, m_din);
    check("tx_valid", tx_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) check("tx_data", tx_data, tx_q[0]);
    check("io_buffer_full", io_buffer_full, m_full);
    check("rx_ready", rx_ready, rst && (rx_q.size() < RXD));
    check("sim_end", sim_end, m_end);
    check("overflow_err", overflow_err, m_ovf);
  endtask

  logic [7:0] exp_full_seq [0:8];
  logic [17:0] ram_addrs [0:7];
  logic [17:0] odd_io [0:3];

  initial begin
    int r, ai;
    logic [31:0] hi;
    logic [17:0] a18;
    exp_full_seq = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'hEE};
    ram_addrs = '{18'h00000, 18'h00123, 18'h0FFFF, 18'h10000, 18'h1FFFF, 18'h2ABCD, 18'h20000, 18'h00001};
    odd_io = '{18'h30001, 18'h30008, 18'h3FFFF, 18'h30005};
    rst = 0; mem_a = 0; mem_wr = 0; mem_dout = 0; tx_ready = 0; rx_valid = 0; rx_data = 0;

    // Reset state
    step(0, RA, 0, 0, 0, 0, 0);
    step(0, RA, 0, 0, 0, 0, 0);
    check("rst_mem_din", mem_din, 8'h00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_full", io_buffer_full, 1'b0);
    check("rst_rx_ready_held", rx_ready, 1'b0);
    check("rst_sim_end", sim_end, 1'b0);
    check("rst_ovf", overflow_err, 1'b0);

    // RAM write/readback
    step(1, 32'h124, 1, 8'h5A, 0, 0, 0);
    check("rx_ready_released", rx_ready, 1'b1);
    step(1, RA, 1, 8'hA5, 0, 0, 0);
    step(1, 32'h124, 0, 0, 0, 0, 0);
    check("ram_rd_124", mem_din, 8'h5A);
    step(1, RA, 0, 0, 0, 0, 0);
    check("ram_rd_123", mem_din, 8'hA5);

    // TX stream
    sent_q.delete();
    step(1, P0, 1, 8'h48, 1, 0, 0);
    step(1, P0, 1, 8'h69, 1, 0, 0);
    step(1, P0, 1, 8'h0A, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, RA, 0, 0, 1, 0, 0);
    check("tx_stream_len", sent_q.size(), 3);
    if (sent_q.size() == 3) begin
      check("tx_stream_0", sent_q[0], 8'h48);
      check("tx_stream_1", sent_q[1], 8'h69);
      check("tx_stream_2", sent_q[2], 8'h0A);
    end
    check("tx_stream_idle", tx_valid, 1'b0);
    check("tx_stream_ovf", overflow_err, 1'b0);

    // RX path
    step(1, RA, 0, 0, 0, 1, 8'h31);
    step(1, P1, 0, 0, 0, 0, 0);
    check("rx_status_full", mem_din, 8'h01);
    step(1, P0, 0, 0, 0, 0, 0);
    check("rx_pop", mem_din, 8'h31);
    step(1, P1, 0, 0, 0, 0, 0);
    check("rx_status_empty", mem_din, 8'h00);
    step(1, P0, 0, 0, 0, 0, 0);
    check("rx_pop_empty", mem_din, 8'h00);

    // Full threshold and overflow
    sent_q.delete();
    for (int i = 1; i <= 9; i++) begin
      step(1, P0, 1, 8'h80 + 8'(i), 0, 0, 0);
      if (i == 5) check("full_after5", io_buffer_full, 1'b0);
      if (i == 6) check("full_after6", io_buffer_full, 1'b1);
      if (i == 8) check("ovf_after8", overflow_err, 1'b0);
      if (i == 9) check("ovf_after9", overflow_err, 1'b1);
    end
    step(1, RA, 0, 0, 1, 0, 0);
    step(1, RA, 0, 0, 1, 0, 0);
    step(1, P0, 1, 8'hEE, 1, 0, 0);
    check("full_pushpop_at6", io_buffer_full, 1'b1);
    for (int i = 0; i < 8; i++) step(1, RA, 0, 0, 1, 0, 0);
    check("full_seq_len", sent_q.size(), 9);
    if (sent_q.size() == 9)
      for (int k = 0; k < 9; k++) check("full_seq", sent_q[k], exp_full_seq[k]);

    // End flag, then reset mid-drain
    step(1, P1, 1, 0, 0, 0, 0);
    check("sim_end_set", sim_end, 1'b1);
    for (int i = 0; i < 3; i++) step(1, RA, 0, 0, 0, 0, 0);
    check("sim_end_sticky", sim_end, 1'b1);
    for (int i = 0; i < 4; i++) step(1, P0, 1, 8'hC1 + 8'(i), 0, 0, 0);
    step(1, RA, 0, 0, 1, 0, 0);
    step(0, RA, 1, 8'h00, 1, 0, 0);
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_sim_end", sim_end, 1'b0);
    check("mid_rst_full", io_buffer_full, 1'b0);
    check("mid_rst_ovf", overflow_err, 1'b0);
    check("mid_rst_mem_din", mem_din, 8'h00);
    step(1, RA, 0, 0, 0, 0, 0);
    check("ram_kept", mem_din, 8'hA5);
    check("rx_ready_after_rst", rx_ready, 1'b1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 45) begin
        ai = $urandom_range(0, 7);
        a18 = ram_addrs[ai];
      end else if (r < 70) a18 = 18'h30000;
      else if (r < 85) a18 = 18'h30004;
      else begin
        ai = $urandom_range(0, 3);
        a18 = odd_io[ai];
      end
      hi = $urandom;
      step(($urandom_range(0, 149) != 0), {hi[13:0], a18}, 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), ($urandom_range(0, 99) < 40),
           ($urandom_range(0, 99) < 40), 8'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
